// File: rtl/wheel_driver.sv
// ---------------------------------------------------------------------------
// wheel_driver
//
// Drives one wheel motor from a 3-bit one-hot action code. It ramps the PWM
// duty up to a run level, holds it there, and ramps it back down. Between
// any stop and the next start the motor sits braked for a fixed dwell. The
// direction output only changes while the wheel is fully stopped, so a
// reversal always passes through ramp-down, the braked dwell, and idle.
//
// Optional feature macro: WHEEL_DRIVER_SOFTSTART_EN
//   defined   : duty ramps by 1 LSB every RAMP_DIV clocks.
//   undefined : duty jumps straight to DUTY_MAX or to 0 in a single clock.
//               RAMP_DIV does not change behaviour in this build.
//
// Parameters
//   DUTY_MAX    run duty in 1/256 units (1..255)
//   RAMP_DIV    clocks per 1-LSB duty step while ramping (>= 1)
//   DEAD_CYCLES braked dwell in clocks after duty reaches zero (>= 1)
//
// Ports
//   CLOCK_50  in   sole clock, rising edge only
//   reset     in   synchronous, active-high
//   act[2:0]  in   3'b100 reverse, 3'b010 forward, 3'b001 stop;
//                  any other code is treated as stop
//   pwm       out  motor enable PWM, registered (pwm_cnt < duty)
//   dir       out  1 = forward, 0 = reverse
//   brake     out  1 = braked (IDLE and DEAD)
//   busy      out  high in RAMP_UP, RAMP_DOWN and DEAD
//   act_err   out  one-clock pulse after an invalid act code is sampled
// ---------------------------------------------------------------------------
module wheel_driver #(
    parameter int DUTY_MAX    = 200,
    parameter int RAMP_DIV    = 1000,
    parameter int DEAD_CYCLES = 5000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] act,
    output logic       pwm,
    output logic       dir,
    output logic       brake,
    output logic       busy,
    output logic       act_err
);

    localparam logic [2:0] ACT_REV  = 3'b100;
    localparam logic [2:0] ACT_FWD  = 3'b010;
    localparam logic [2:0] ACT_STOP = 3'b001;

    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [7:0]         DUTY_RUN   = 8'(DUTY_MAX);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        RUN,
        RAMP_DOWN,
        DEAD
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          duty_q, duty_d;
    logic [7:0]          pwm_cnt_q, pwm_cnt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic                pwm_q, pwm_d;
    logic                dir_q, dir_d;
    logic                brake_q, brake_d;
    logic                busy_q, busy_d;
    logic                act_err_q, act_err_d;

    logic                act_fwd;
    logic                act_rev;
    logic                hold_dir;
    logic                presc_wrap;

    // Decode the action code. hold_dir means "the command still asks for the
    // direction we are already driving"; anything else (stop, invalid code or
    // the opposite direction) is a request to slow down.
    always_comb begin
        act_fwd    = (act == ACT_FWD);
        act_rev    = (act == ACT_REV);
        hold_dir   = dir_q ? act_fwd : act_rev;
        presc_wrap = (presc_q == PRESC_LAST);
    end

    // Next-state logic. The prescaler free-runs modulo RAMP_DIV inside a state
    // and is forced back to zero whenever the state changes, so every ramp
    // step is timed from the moment the state was entered. The dwell counter
    // only advances in DEAD and is zero everywhere else.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        dead_d    = '0;
        presc_d   = presc_wrap ? '0 : presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_d     = (pwm_cnt_q < duty_q);
        act_err_d = !(act_fwd || act_rev || (act == ACT_STOP));

        case (state_q)
            IDLE: begin
                duty_d = 8'd0;
                if (act_fwd) begin
                    dir_d   = 1'b1;
                    state_d = RAMP_UP;
                end else if (act_rev) begin
                    dir_d   = 1'b0;
                    state_d = RAMP_UP;
                end
            end

            RAMP_UP: begin
                if (!hold_dir) begin
                    state_d = RAMP_DOWN;
                end else begin
`ifdef WHEEL_DRIVER_SOFTSTART_EN
                    // Re-entry from RAMP_DOWN can happen with duty already at
                    // the run level, in which case there is nothing to ramp.
                    if (duty_q >= DUTY_RUN) begin
                        duty_d  = DUTY_RUN;
                        state_d = RUN;
                    end else if (presc_wrap) begin
                        duty_d = duty_q + 8'd1;
                        if ((duty_q + 8'd1) == DUTY_RUN) begin
                            state_d = RUN;
                        end
                    end
`else
                    duty_d  = DUTY_RUN;
                    state_d = RUN;
`endif
                end
            end

            RUN: begin
                duty_d = DUTY_RUN;
                if (!hold_dir) begin
                    state_d = RAMP_DOWN;
                end
            end

            RAMP_DOWN: begin
                // A renewed request for the current direction resumes the
                // ramp-up from whatever duty has been reached.
                if (hold_dir) begin
                    state_d = RAMP_UP;
                end else begin
`ifdef WHEEL_DRIVER_SOFTSTART_EN
                    if (duty_q == 8'd0) begin
                        state_d = DEAD;
                    end else if (presc_wrap) begin
                        duty_d = duty_q - 8'd1;
                        if (duty_q == 8'd1) begin
                            state_d = DEAD;
                        end
                    end
`else
                    duty_d  = 8'd0;
                    state_d = DEAD;
`endif
                end
            end

            DEAD: begin
                duty_d = 8'd0;
                if (dead_q == DEAD_LAST) begin
                    state_d = IDLE;
                end else begin
                    dead_d = dead_q + 1'b1;
                end
            end

            default: begin
                duty_d  = 8'd0;
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            dead_d  = '0;
        end

        // brake and busy are registered from the next state so that they
        // always line up with the registered state itself.
        brake_d = (state_d == IDLE) || (state_d == DEAD);
        busy_d  = (state_d == RAMP_UP) || (state_d == RAMP_DOWN) ||
                  (state_d == DEAD);
    end

    // State and output registers. Reset brakes the motor at once, with no
    // ramp-down, from any state.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            duty_q    <= 8'd0;
            pwm_cnt_q <= 8'd0;
            presc_q   <= '0;
            dead_q    <= '0;
            pwm_q     <= 1'b0;
            dir_q     <= 1'b1;
            brake_q   <= 1'b1;
            busy_q    <= 1'b0;
            act_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            dead_q    <= dead_d;
            pwm_q     <= pwm_d;
            dir_q     <= dir_d;
            brake_q   <= brake_d;
            busy_q    <= busy_d;
            act_err_q <= act_err_d;
        end
    end

    assign pwm     = pwm_q;
    assign dir     = dir_q;
    assign brake   = brake_q;
    assign busy    = busy_q;
    assign act_err = act_err_q;

endmodule
